// File: rtl/simmem_multi_id_linkedlist_bank_pkg.sv
// Shared configuration types and width helpers for the simulated-memory message banks.
package simmem_pkg;

  typedef struct packed {
    int unsigned message_width;
    int unsigned num_ids;
    int unsigned total_capacity;
  } simmem_multi_bank_cfg_t;

  localparam simmem_multi_bank_cfg_t DefaultCfg = '{
    message_width:  64,
    num_ids:        4,
    total_capacity: 32
  };

  function automatic int id_width(input int num_ids);
    return (num_ids <= 1) ? 1 : $clog2(num_ids);
  endfunction

  function automatic int addr_width(input int total_capacity);
    return $clog2(total_capacity);
  endfunction

endpackage

// File: rtl/simmem_multi_id_linkedlist_bank_if.sv
// Bundle of the push, release and status signals of the per-ID linked-list bank.
interface simmem_multi_id_linkedlist_bank_if
  import simmem_pkg::*;
#(
  parameter int MessageWidth  = 64,
  parameter int NumIds        = 4,
  parameter int TotalCapacity = 32
);
  localparam int IdWidth    = id_width(NumIds);
  localparam int AddrWidth  = addr_width(TotalCapacity);
  localparam int CountWidth = AddrWidth + 1;

  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [IdWidth-1:0]           in_id_i;
  logic [MessageWidth-1:0]      in_data_i;
  logic [AddrWidth-1:0]         in_addr_o;
  logic [IdWidth-1:0]           release_id_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [MessageWidth-1:0]      out_data_o;
  logic [NumIds*CountWidth-1:0] id_count_o;
  logic                         full_o;
  logic                         empty_o;

  modport master (
    output in_valid_i, in_id_i, in_data_i, release_id_i, out_ready_i,
    input  in_ready_o, in_addr_o, out_valid_o, out_data_o, id_count_o, full_o, empty_o
  );

  modport slave (
    input  in_valid_i, in_id_i, in_data_i, release_id_i, out_ready_i,
    output in_ready_o, in_addr_o, out_valid_o, out_data_o, id_count_o, full_o, empty_o
  );

endinterface

// File: rtl/simmem_multi_id_linkedlist_bank_lowest_zero_enc.sv
// Finds the lowest-index zero bit of a vector: one-hot, binary index and an any-zero flag.
module simmem_lowest_zero_enc #(
  parameter int Width = 8,
  localparam int IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    vec,
  output logic [Width-1:0]    onehot,
  output logic [IdxWidth-1:0] index,
  output logic                any_zero
);

  // Scanning downwards lets the lowest zero overwrite any higher hit.
  always_comb begin
    onehot   = '0;
    index    = '0;
    any_zero = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (!vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IdxWidth'(i);
        any_zero  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_multi_id_linkedlist_bank.sv
// Shared-pool message store holding one FIFO linked list per ID; heads are read combinationally.
module simmem_multi_id_linkedlist_bank
  import simmem_pkg::*;
#(
  parameter int MessageWidth  = int'(DefaultCfg.message_width),
  parameter int NumIds        = int'(DefaultCfg.num_ids),
  parameter int TotalCapacity = int'(DefaultCfg.total_capacity)
) (
  input logic clk_i,
  input logic rst_i,
  simmem_multi_id_linkedlist_bank_if.slave bus
);
  localparam int IdWidth    = id_width(NumIds);
  localparam int AddrWidth  = addr_width(TotalCapacity);
  localparam int CountWidth = AddrWidth + 1;

  logic [TotalCapacity-1:0] valid_vec;
  logic [TotalCapacity-1:0] free_onehot;
  logic [AddrWidth-1:0]     free_idx;
  logic                     any_free;

  logic [MessageWidth-1:0]  data_q  [TotalCapacity];
  logic [AddrWidth-1:0]     next_q  [TotalCapacity];
  logic [AddrWidth-1:0]     head_q  [NumIds];
  logic [AddrWidth-1:0]     tail_q  [NumIds];
  logic [CountWidth-1:0]    count_q [NumIds];

  logic                     in_hs;
  logic                     out_valid;
  logic                     out_hs;
  logic                     in_list_nonempty;
  logic [AddrWidth-1:0]     head_rel;
  logic [AddrWidth-1:0]     tail_in;

  simmem_lowest_zero_enc #(.Width(TotalCapacity)) u_free_enc (
    .vec      (valid_vec),
    .onehot   (free_onehot),
    .index    (free_idx),
    .any_zero (any_free)
  );

  assign in_hs            = bus.in_valid_i && any_free;
  assign out_valid        = (count_q[bus.release_id_i] != '0);
  assign out_hs           = out_valid && bus.out_ready_i;
  assign head_rel         = head_q[bus.release_id_i];
  assign tail_in          = tail_q[bus.in_id_i];
  assign in_list_nonempty = (count_q[bus.in_id_i] != '0);

  // Per-ID list bookkeeping; a same-ID push and pop leaves the count unchanged.
  for (genvar g = 0; g < NumIds; g++) begin : g_list
    logic                  push;
    logic                  pop;
    logic [AddrWidth-1:0]  head_r;
    logic [AddrWidth-1:0]  tail_r;
    logic [CountWidth-1:0] count_r;

    assign push = in_hs && (bus.in_id_i == IdWidth'(g));
    assign pop  = out_hs && (bus.release_id_i == IdWidth'(g));

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        if (push) tail_r <= free_idx;
        if (push && ((count_r == '0) || (pop && (count_r == CountWidth'(1))))) head_r <= free_idx;
        else if (pop) head_r <= next_q[head_r];
        if (push && !pop) count_r <= count_r + CountWidth'(1);
        else if (pop && !push) count_r <= count_r - CountWidth'(1);
      end
    end

    assign head_q[g]  = head_r;
    assign tail_q[g]  = tail_r;
    assign count_q[g] = count_r;
    assign bus.id_count_o[g*CountWidth +: CountWidth] = count_r;
  end

  // Entry storage; payload and link words need no reset because valid gates them.
  for (genvar e = 0; e < TotalCapacity; e++) begin : g_entry
    logic                    alloc;
    logic                    release_e;
    logic                    link;
    logic                    valid_r;
    logic [MessageWidth-1:0] data_r;
    logic [AddrWidth-1:0]    next_r;

    assign alloc     = in_hs && free_onehot[e];
    assign release_e = out_hs && (head_rel == AddrWidth'(e));
    assign link      = in_hs && in_list_nonempty && (tail_in == AddrWidth'(e));

    always_ff @(posedge clk_i) begin
      if (rst_i) valid_r <= 1'b0;
      else if (alloc) valid_r <= 1'b1;
      else if (release_e) valid_r <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
      if (alloc) data_r <= bus.in_data_i;
      if (link) next_r <= free_idx;
    end

    assign valid_vec[e] = valid_r;
    assign data_q[e]    = data_r;
    assign next_q[e]    = next_r;
  end

  assign bus.in_ready_o  = any_free;
  assign bus.in_addr_o   = free_idx;
  assign bus.full_o      = !any_free;
  assign bus.empty_o     = (valid_vec == '0);
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = data_q[head_rel];

  int count_sum;

  always_comb begin
    count_sum = 0;
    for (int i = 0; i < NumIds; i++) count_sum += int'(count_q[i]);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_sum == $countones(valid_vec));
      assert (!(out_hs && !valid_vec[head_rel]));
      assert (!(in_hs && valid_vec[free_idx]));
      assert (!bus.in_valid_i || (int'(bus.in_id_i) < NumIds));
    end
  end

endmodule

// File: tb/tb_simmem_multi_id_linkedlist_bank.sv
// Bench for the per-ID linked-list bank: directed vector table, corner sequences and a queue-model random run.
module tb_simmem_multi_id_linkedlist_bank;

  localparam int MW = 64;
  localparam int NI = 4;
  localparam int TC = 32;
  localparam int IW = 2;
  localparam int AW = 5;
  localparam int CW = AW + 1;

  localparam logic [MW-1:0] DA = 64'hA000_0000_0000_00A1;
  localparam logic [MW-1:0] DB = 64'hB000_0000_0000_00B2;
  localparam logic [MW-1:0] DC = 64'hC000_0000_0000_00C3;
  localparam logic [MW-1:0] DX = 64'h1111_2222_3333_4444;
  localparam logic [MW-1:0] DY = 64'h5555_6666_7777_8888;
  localparam logic [MW-1:0] DZ = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [MW-1:0] DW = 64'hDDDD_EEEE_FFFF_0001;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  simmem_multi_id_linkedlist_bank_if #(.MessageWidth(MW), .NumIds(NI), .TotalCapacity(TC)) bus ();

  simmem_multi_id_linkedlist_bank #(.MessageWidth(MW), .NumIds(NI), .TotalCapacity(TC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic          iv;
    logic [IW-1:0] id;
    logic [MW-1:0] d;
    logic [IW-1:0] rel;
    logic          ordy;
    logic          e_ready;
    logic [AW-1:0] e_addr;
    logic          e_ov;
    logic [MW-1:0] e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [15];

  // Scoreboard: one queue of payloads (and occupied entries) per ID, plus an occupancy map.
  logic [MW-1:0] mq_data [NI][$];
  int            mq_addr [NI][$];
  bit            m_used  [TC];

  int total_checks = 0;
  int bad_checks   = 0;

  function automatic int m_free();
    for (int i = 0; i < TC; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  function automatic int m_total();
    int s = 0;
    for (int i = 0; i < NI; i++) s += mq_data[i].size();
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) begin
      mq_data[i].delete();
      mq_addr[i].delete();
    end
    for (int i = 0; i < TC; i++) m_used[i] = 1'b0;
  endtask

  task automatic doReset(input int n, input logic traffic);
    rst = 1'b1;
    bus.in_valid_i  = traffic;
    bus.out_ready_i = traffic;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    modelReset();
  endtask

  task automatic applyStimulus(input logic iv, input logic [IW-1:0] id, input logic [MW-1:0] d,
                               input logic [IW-1:0] rel, input logic ordy);
    bus.in_valid_i   = iv;
    bus.in_id_i      = id;
    bus.in_data_i    = d;
    bus.release_id_i = rel;
    bus.out_ready_i  = ordy;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    int f   = m_free();
    int rel = int'(bus.release_id_i);
    chk({tag, " in_ready"}, 64'(bus.in_ready_o), 64'(f >= 0));
    chk({tag, " full"}, 64'(bus.full_o), 64'(f < 0));
    if (f >= 0) chk({tag, " in_addr"}, 64'(bus.in_addr_o), 64'(f));
    chk({tag, " empty"}, 64'(bus.empty_o), 64'(m_total() == 0));
    chk({tag, " out_valid"}, 64'(bus.out_valid_o), 64'(mq_data[rel].size() != 0));
    if (mq_data[rel].size() != 0) chk({tag, " out_data"}, bus.out_data_o, mq_data[rel][0]);
    for (int i = 0; i < NI; i++)
      chk($sformatf("%s count%0d", tag, i), 64'(bus.id_count_o[i*CW +: CW]), 64'(mq_data[i].size()));
  endtask

  task automatic endCycle();
    int f   = m_free();
    int rel = int'(bus.release_id_i);
    int id  = int'(bus.in_id_i);
    bit do_pop  = bus.out_ready_i && (mq_data[rel].size() != 0);
    bit do_push = bus.in_valid_i && (f >= 0);
    if (do_pop) begin
      m_used[mq_addr[rel][0]] = 1'b0;
      void'(mq_data[rel].pop_front());
      void'(mq_addr[rel].pop_front());
    end
    if (do_push) begin
      m_used[f] = 1'b1;
      mq_data[id].push_back(bus.in_data_i);
      mq_addr[id].push_back(f);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag, input logic iv, input logic [IW-1:0] id, input logic [MW-1:0] d,
                       input logic [IW-1:0] rel, input logic ordy);
    applyStimulus(iv, id, d, rel, ordy);
    checkOutput(tag);
    endCycle();
  endtask

  function automatic logic [CW-1:0] cnt(input int id);
    return bus.id_count_o[id*CW +: CW];
  endfunction

  initial begin
    logic [MW-1:0] drain_exp [3];

    rst = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.in_id_i      = '0;
    bus.in_data_i    = '0;
    bus.release_id_i = '0;
    bus.out_ready_i  = 1'b0;

    vecs[0]  = '{1'b1, 2'd1, DA, 2'd1, 1'b0, 1'b1, 5'd0, 1'b0, '0, 6'd0};
    vecs[1]  = '{1'b1, 2'd1, DB, 2'd1, 1'b0, 1'b1, 5'd1, 1'b1, DA, 6'd1};
    vecs[2]  = '{1'b1, 2'd1, DC, 2'd1, 1'b0, 1'b1, 5'd2, 1'b1, DA, 6'd2};
    vecs[3]  = '{1'b0, 2'd0, '0, 2'd1, 1'b1, 1'b1, 5'd3, 1'b1, DA, 6'd3};
    vecs[4]  = '{1'b0, 2'd0, '0, 2'd1, 1'b1, 1'b1, 5'd0, 1'b1, DB, 6'd2};
    vecs[5]  = '{1'b0, 2'd0, '0, 2'd1, 1'b1, 1'b1, 5'd0, 1'b1, DC, 6'd1};
    vecs[6]  = '{1'b0, 2'd0, '0, 2'd1, 1'b0, 1'b1, 5'd0, 1'b0, '0, 6'd0};
    vecs[7]  = '{1'b1, 2'd0, DX, 2'd0, 1'b0, 1'b1, 5'd0, 1'b0, '0, 6'd0};
    vecs[8]  = '{1'b1, 2'd2, DY, 2'd0, 1'b0, 1'b1, 5'd1, 1'b1, DX, 6'd1};
    vecs[9]  = '{1'b1, 2'd0, DZ, 2'd2, 1'b0, 1'b1, 5'd2, 1'b1, DY, 6'd1};
    vecs[10] = '{1'b0, 2'd0, '0, 2'd2, 1'b1, 1'b1, 5'd3, 1'b1, DY, 6'd1};
    vecs[11] = '{1'b1, 2'd2, DW, 2'd0, 1'b1, 1'b1, 5'd1, 1'b1, DX, 6'd2};
    vecs[12] = '{1'b0, 2'd0, '0, 2'd0, 1'b1, 1'b1, 5'd0, 1'b1, DZ, 6'd1};
    vecs[13] = '{1'b0, 2'd0, '0, 2'd2, 1'b1, 1'b1, 5'd0, 1'b1, DW, 6'd1};
    vecs[14] = '{1'b0, 2'd0, '0, 2'd2, 1'b0, 1'b1, 5'd0, 1'b0, '0, 6'd0};

    doReset(2, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    chk("reset in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("reset in_addr", 64'(bus.in_addr_o), 64'd0);
    chk("reset out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("reset full", 64'(bus.full_o), 64'd0);
    chk("reset empty", 64'(bus.empty_o), 64'd1);
    chk("reset counts", 64'(bus.id_count_o), 64'd0);
    checkOutput("reset");
    endCycle();

    // Ordering on one ID, then interleaved IDs with entry reuse.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].d, vecs[i].rel, vecs[i].ordy);
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready_o), 64'(vecs[i].e_ready));
      chk($sformatf("vec%0d in_addr", i), 64'(bus.in_addr_o), 64'(vecs[i].e_addr));
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid_o), 64'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d out_data", i), bus.out_data_o, vecs[i].e_data);
      chk($sformatf("vec%0d rel_count", i), 64'(cnt(int'(vecs[i].rel))), 64'(vecs[i].e_cnt));
      checkOutput($sformatf("vec%0d", i));
      endCycle();
    end

    // Fill the pool on ID3, stall the 33rd push, then free one entry.
    for (int i = 0; i < TC; i++) cycle("fill", 1'b1, 2'd3, 64'(100 + i), 2'd3, 1'b0);
    applyStimulus(1'b1, 2'd3, 64'hFEED, 2'd3, 1'b0);
    chk("full full", 64'(bus.full_o), 64'd1);
    chk("full in_ready", 64'(bus.in_ready_o), 64'd0);
    chk("full count3", 64'(cnt(3)), 64'd32);
    chk("full head", bus.out_data_o, 64'd100);
    checkOutput("full hold");
    endCycle();
    applyStimulus(1'b1, 2'd3, 64'hFEED, 2'd3, 1'b1);
    chk("full release in_ready", 64'(bus.in_ready_o), 64'd0);
    checkOutput("full release");
    endCycle();
    applyStimulus(1'b1, 2'd3, 64'hFEED, 2'd3, 1'b0);
    chk("after release in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("after release in_addr", 64'(bus.in_addr_o), 64'd0);
    chk("after release head", bus.out_data_o, 64'd101);
    checkOutput("after release");
    endCycle();
    applyStimulus(1'b0, 2'd3, '0, 2'd3, 1'b0);
    chk("refull full", 64'(bus.full_o), 64'd1);
    checkOutput("refull");
    endCycle();

    // Reset while traffic is active discards everything.
    doReset(2, 1'b1);
    applyStimulus(1'b0, '0, '0, 2'd3, 1'b0);
    chk("midreset in_ready", 64'(bus.in_ready_o), 64'd1);
    chk("midreset in_addr", 64'(bus.in_addr_o), 64'd0);
    chk("midreset empty", 64'(bus.empty_o), 64'd1);
    chk("midreset out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("midreset counts", 64'(bus.id_count_o), 64'd0);
    checkOutput("midreset");
    endCycle();

    // Same-ID push and release with one entry, then with three.
    cycle("same p", 1'b1, 2'd0, 64'h50, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd0, 64'h51, 2'd0, 1'b1);
    chk("same1 out_data", bus.out_data_o, 64'h50);
    chk("same1 in_addr", 64'(bus.in_addr_o), 64'd1);
    checkOutput("same1");
    endCycle();
    applyStimulus(1'b0, 2'd0, '0, 2'd0, 1'b0);
    chk("same1 count0", 64'(cnt(0)), 64'd1);
    chk("same1 next", bus.out_data_o, 64'h51);
    checkOutput("same1 after");
    endCycle();
    cycle("same r", 1'b1, 2'd0, 64'h52, 2'd0, 1'b0);
    cycle("same s", 1'b1, 2'd0, 64'h53, 2'd0, 1'b0);
    applyStimulus(1'b1, 2'd0, 64'h54, 2'd0, 1'b1);
    chk("same3 out_data", bus.out_data_o, 64'h51);
    chk("same3 count0", 64'(cnt(0)), 64'd3);
    checkOutput("same3");
    endCycle();
    drain_exp[0] = 64'h52;
    drain_exp[1] = 64'h53;
    drain_exp[2] = 64'h54;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, '0, 2'd0, 1'b1);
      chk($sformatf("drain%0d data", i), bus.out_data_o, drain_exp[i]);
      chk($sformatf("drain%0d count0", i), 64'(cnt(0)), 64'(3 - i));
      checkOutput($sformatf("drain%0d", i));
      endCycle();
    end

    // Random traffic against the queue model.
    for (int n = 0; n < 10000; n++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), IW'($urandom_range(0, NI - 1)),
            {$urandom, $urandom}, IW'($urandom_range(0, NI - 1)), ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
